// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer in front of dmem.
// Holds the dmem memop encodings, the sequencer state enum and the
// default size of the dmem byte space.
package lsu_dmem_ctrl_pkg;

  localparam logic [2:0] MOP_W  = 3'b000;
  localparam logic [2:0] MOP_B  = 3'b001;
  localparam logic [2:0] MOP_H  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b101;
  localparam logic [2:0] MOP_HU = 3'b110;

  // First byte address outside dmem (17-bit byte space).
  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0002_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_HI = 3'd1,
    ST_RD_LO = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_dmem_ctrl_access_check.sv
// lsu_access_check: combinational error decode for one dmem access.
// Ports:
//   op   - dmem memop
//   we   - 1 = store
//   addr - byte address
//   err  - illegal op, store with unsigned op, misaligned h/w, or out of range
module lsu_access_check
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic [2:0]  op,
  input  logic        we,
  input  logic [31:0] addr,
  output logic        err
);

  always_comb begin
    err = 1'b0;
    case (op)
      MOP_W:   err = (addr[1:0] != 2'b00);
      MOP_B:   err = 1'b0;
      MOP_H:   err = addr[0];
      MOP_BU:  err = we;             // unsigned variants are load-only
      MOP_HU:  err = we | addr[0];
      default: err = 1'b1;
    endcase
    if (addr >= ADDR_LIMIT) err = 1'b1;
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store sequencer between the core memory stage and
// the dual-clock dmem. One request at a time; generates the dmem read
// strobe (sampled on its falling edge) and write strobe (commit on its
// rising edge) from clk, and returns load data / store completion.
// Ports:
//   clk, rst_n                       - system clock, async active-low reset
//   req_valid/req_ready/req_we/req_op/req_addr/req_wdata - request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                - response channel
//   dmem_addr/datain/op/we/rdclk/wrclk, dmem_dataout     - dmem interface
//   stat_loads/stat_stores/stat_errs - saturating counters (LSU_STATS_EN only)
// Optional feature macro: LSU_STATS_EN.
// All outputs are registered.
module lsu_dmem_ctrl
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int          STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       dmem_addr,
  output logic [31:0]       dmem_datain,
  output logic [2:0]        dmem_op,
  output logic              dmem_we,
  output logic              dmem_rdclk,
  output logic              dmem_wrclk,
`ifdef LSU_STATS_EN
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errs,
`endif
  input  logic [31:0]       dmem_dataout
);

  lsu_state_t  state, nxt_state;
  logic        nxt_req_ready, nxt_rsp_valid, nxt_rsp_err;
  logic [31:0] nxt_rsp_rdata, nxt_addr, nxt_datain;
  logic [2:0]  nxt_op;
  logic        nxt_we, nxt_rdclk, nxt_wrclk;
  logic        acc_err;

  lsu_access_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_chk (
    .op   (req_op),
    .we   (req_we),
    .addr (req_addr),
    .err  (acc_err)
  );

  always_comb begin
    nxt_state     = state;
    nxt_req_ready = req_ready;
    nxt_rsp_valid = rsp_valid;
    nxt_rsp_err   = rsp_err;
    nxt_rsp_rdata = rsp_rdata;
    nxt_addr      = dmem_addr;
    nxt_datain    = dmem_datain;
    nxt_op        = dmem_op;
    nxt_we        = dmem_we;
    nxt_rdclk     = 1'b0;
    nxt_wrclk     = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        nxt_req_ready = 1'b0;
        nxt_addr      = req_addr;
        nxt_datain    = req_wdata;
        nxt_op        = req_op;
        nxt_rsp_rdata = '0;
        if (acc_err) begin
          // Skip the strobe sequence entirely so dmem is never touched.
          nxt_state     = ST_RESP;
          nxt_rsp_valid = 1'b1;
          nxt_rsp_err   = 1'b1;
          nxt_we        = 1'b0;
        end else begin
          nxt_state   = ST_RD_HI;
          nxt_rsp_err = 1'b0;
          nxt_we      = req_we;
          nxt_rdclk   = 1'b1;
        end
      end
      ST_RD_HI: nxt_state = ST_RD_LO;  // rdclk falls entering RD_LO
      ST_RD_LO: begin
        if (dmem_we) begin
          // Old word is now captured inside dmem for byte merging.
          nxt_state = ST_WR;
          nxt_wrclk = 1'b1;
        end else begin
          nxt_state     = ST_RESP;
          nxt_rsp_valid = 1'b1;
          nxt_rsp_rdata = dmem_dataout;
        end
      end
      ST_WR: begin
        nxt_state     = ST_RESP;
        nxt_rsp_valid = 1'b1;
      end
      ST_RESP: if (rsp_ready) begin
        nxt_state     = ST_IDLE;
        nxt_rsp_valid = 1'b0;
        nxt_we        = 1'b0;
        nxt_req_ready = 1'b1;
      end
      default: begin
        nxt_state     = ST_IDLE;
        nxt_req_ready = 1'b1;
        nxt_rsp_valid = 1'b0;
        nxt_we        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      dmem_addr   <= '0;
      dmem_datain <= '0;
      dmem_op     <= MOP_W;
      dmem_we     <= 1'b0;
      dmem_rdclk  <= 1'b0;
      dmem_wrclk  <= 1'b0;
    end else begin
      state       <= nxt_state;
      req_ready   <= nxt_req_ready;
      rsp_valid   <= nxt_rsp_valid;
      rsp_rdata   <= nxt_rsp_rdata;
      rsp_err     <= nxt_rsp_err;
      dmem_addr   <= nxt_addr;
      dmem_datain <= nxt_datain;
      dmem_op     <= nxt_op;
      dmem_we     <= nxt_we;
      dmem_rdclk  <= nxt_rdclk;
      dmem_wrclk  <= nxt_wrclk;
    end
  end

`ifdef LSU_STATS_EN
  logic rsp_hs;
  assign rsp_hs = (state == ST_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (rsp_hs) begin
      if (rsp_err) begin
        if (stat_errs != '1) stat_errs <= stat_errs + 1'b1;
      end else if (dmem_we) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 1'b1;
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + 1'b1;
      end
    end
  end
`endif

endmodule
